// File: rtl/rf_read_arbiter_pkg.sv
// Shared register-file types and helpers for the read-port arbiter and its
// round-robin grant logic.
package rf_read_arbiter_pkg;
  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int REG_ZERO = 0;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  typedef enum logic {IDLE, HOLD} rf_arb_state_t;

  // Modulo-n for 0 <= i < 2n; keeps non-power-of-two pointers wrapping at n.
  function automatic int rr_wrap(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction
endpackage

// File: rtl/rf_read_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first set request at or after ptr,
// modulo N. Shared with the write-port arbiter.
module rr_arbiter
  import rf_read_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Scan farthest-first so the nearest requester after ptr wins.
    for (int k = N-1; k >= 0; k--) begin
      if (en && req[rr_wrap(int'(ptr) + k, N)]) begin
        idx = IW'(rr_wrap(int'(ptr) + k, N));
        any = 1'b1;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/rf_read_arbiter.sv
// Shares one register-file read port among NREQ requesters; round-robin
// grant, one response slot, back-to-back reads when rsp_ready stays high.
module rf_read_arbiter
  import rf_read_arbiter_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int AW       = REG_AW,
  parameter  int DW       = REG_DW,
  parameter  int ZERO_REG = 1,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [AW-1:0]     rd_sel,
  input  logic [DW-1:0]     rd_data,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [DW-1:0]     rsp_data,
  input  logic              rsp_ready
);
  rf_arb_state_t state, state_nxt;
  logic [IW-1:0] ptr, gnt_idx;
  logic          gnt_any, slot_free;
  logic [NREQ-1:0][AW-1:0] addr;

  for (genvar i = 0; i < NREQ; i++) begin : g_addr
    assign addr[i] = req_addr[i*AW +: AW];
  end

  assign rsp_valid = (state == HOLD);
  // rst_n gates the enable so nothing is granted while reset is held.
  assign slot_free = rst_n && ((state == IDLE) || rsp_ready);

  rr_arbiter #(.N(NREQ)) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .en  (slot_free),
    .gnt (req_ready),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign rd_sel = gnt_any ? addr[gnt_idx] : '0;

  always_comb begin
    state_nxt = state;
    if (gnt_any)                        state_nxt = HOLD;
    else if (state == HOLD && rsp_ready) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else if (gnt_any) begin
      ptr      <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      rsp_id   <= gnt_idx;
      rsp_data <= (ZERO_REG != 0 && rd_sel == '0) ? '0 : rd_data;
    end
  end
endmodule

// File: tb/tb_rf_read_arbiter.sv
// Scoreboard bench: a round-robin reference model predicts grants and pushes
// expected responses; a monitor pops and compares whatever the DUT returns.
module tb_rf_read_arbiter;
  localparam int NREQ = 4, AW = 5, DW = 32, IW = 2;

  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*AW-1:0] req_addr  = '0;
  logic [NREQ-1:0] req_ready, req_ready_nz;
  logic [AW-1:0]   rd_sel, rd_sel_nz;
  logic [DW-1:0]   rd_data, rd_data_nz, rsp_data, rsp_data_nz;
  logic [IW-1:0]   rsp_id, rsp_id_nz;
  logic            rsp_valid, rsp_valid_nz;
  logic [DW-1:0]   regs [32];

  assign rd_data    = regs[rd_sel];
  assign rd_data_nz = regs[rd_sel_nz];

  always #5 clk = ~clk;

  rf_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rd_sel(rd_sel), .rd_data(rd_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready));

  rf_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready_nz), .rd_sel(rd_sel_nz), .rd_data(rd_data_nz),
    .rsp_valid(rsp_valid_nz), .rsp_id(rsp_id_nz), .rsp_data(rsp_data_nz), .rsp_ready(rsp_ready));

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] d;
    logic [DW-1:0] dnz;
  } exp_t;
  exp_t q[$];

  int  tests = 0, fails = 0;
  int  ptr_m = 0;
  bit  full_m = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: round-robin from ptr_m over the live request vector.
  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] oh;
    logic [AW-1:0]   a;
    if (rst_n) begin
      chk("rsp_valid", rsp_valid, full_m);
      g = -1;
      if (!full_m || rsp_ready)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
      oh = '0;
      a  = '0;
      if (g >= 0) begin
        oh[g] = 1'b1;
        a = req_addr[g*AW +: AW];
      end
      chk("req_ready", req_ready, oh);
      chk("req_ready_nz", req_ready_nz, oh);
      chk("rd_sel", rd_sel, a);
      if (g >= 0) begin
        q.push_back('{g[IW-1:0], (a == 0) ? '0 : regs[a], regs[a]});
        ptr_m  = (g + 1) % NREQ;
        full_m = 1'b1;
      end else if (rsp_ready) begin
        full_m = 1'b0;
      end
    end
  end

  // Monitor: compare the live response against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        chk("rsp_id", rsp_id, q[0].id);
        chk("rsp_data", rsp_data, q[0].d);
        chk("rsp_valid_nz", rsp_valid_nz, 1);
        chk("rsp_data_nz", rsp_data_nz, q[0].dnz);
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  task automatic cyc(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] ad,
                     input logic rdy, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_valid = v;
      req_addr  = ad;
      rsp_ready = rdy;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[9] = 32'hDEADBEEF;
    regs[0] = 32'hFFFFFFFF;

    // Reset state, with requests present that must not be granted.
    req_valid = '1;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = '0;

    // Single request to r9.
    cyc(4'b0001, {5'd0, 5'd0, 5'd0, 5'd9}, 1'b1, 1);
    cyc(4'b0000, '0, 1'b1, 2);
    // All requesters streaming.
    cyc(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b1, 6);
    cyc(4'b0000, '0, 1'b1, 2);
    // Backpressure with requesters 1 and 2 waiting.
    cyc(4'b0110, {5'd8, 5'd7, 5'd6, 5'd5}, 1'b1, 1);
    cyc(4'b0110, {5'd8, 5'd7, 5'd6, 5'd5}, 1'b0, 3);
    cyc(4'b0110, {5'd8, 5'd7, 5'd6, 5'd5}, 1'b1, 2);
    cyc(4'b0000, '0, 1'b1, 2);
    // Zero register read (r0 holds all-ones in the model).
    cyc(4'b0100, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b1, 1);
    cyc(4'b0000, '0, 1'b1, 2);
    // Wrap: grant 2, then only 0 valid, then 0 and 1.
    cyc(4'b0100, {5'd3, 5'd2, 5'd1, 5'd9}, 1'b1, 1);
    cyc(4'b0001, {5'd3, 5'd2, 5'd1, 5'd9}, 1'b1, 1);
    cyc(4'b0011, {5'd3, 5'd2, 5'd1, 5'd9}, 1'b1, 1);
    cyc(4'b0000, '0, 1'b1, 2);

    // Async reset in the middle of HOLD.
    cyc(4'b0001, {5'd0, 5'd0, 5'd0, 5'd12}, 1'b0, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_req_ready", req_ready, 0);
    q.delete();
    ptr_m  = 0;
    full_m = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(4'b1110, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b1, 1);
    cyc(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b1, 4);
    cyc(4'b0000, '0, 1'b1, 2);

    // Randomized traffic; requests may drop before acceptance.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      req_valid = NREQ'($urandom);
      req_addr  = (NREQ*AW)'($urandom);
      rsp_ready = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) regs[$urandom_range(31)] = $urandom;
    end

    cyc(4'b0000, '0, 1'b1, 4);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
